// File: rtl/mem_march_ctrl.sv
// March C- sequencer driving a single-port RAM and checking every read-back.
// Optional build macro MARCH_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mem_march_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] bg_i,
    output logic              mem_ena_o,
    output logic              mem_wea_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [DATA_W-1:0] first_err_data_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_FIN
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              phase_reg, phase_next;
    logic [1:0]        drain_reg, drain_next;
    logic [DATA_W-1:0] bg_reg;

    logic              in_elem, elem_up, elem_rd, elem_wr, elem_rw;
    logic              rd_one, wr_one, elem_last, op_last, next_up;
    state_t            elem_after;
    logic              rd_issue, wr_issue, start_ok, fin;
    logic [DATA_W-1:0] rd_val, wr_val;

    logic [RD_LAT-1:0]             pipe_vld_reg, pipe_vld_next;
    logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_reg, pipe_addr_next;
    logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp_reg, pipe_exp_next;

    logic              mismatch, count_en, stop_hit;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic [ADDR_W-1:0] first_addr_reg;
    logic [DATA_W-1:0] first_data_reg;
    logic              pass_reg;

    // Element table: direction, read/write ops, polarity ("1" = ~background), successor.
    always_comb begin
        in_elem    = 1'b1;
        elem_up    = 1'b1;
        elem_rd    = 1'b1;
        elem_wr    = 1'b1;
        rd_one     = 1'b0;
        wr_one     = 1'b0;
        elem_after = S_DRAIN;
        case (state_reg)
            S_M0: begin elem_rd = 1'b0; elem_after = S_M1; end
            S_M1: begin wr_one = 1'b1; elem_after = S_M2; end
            S_M2: begin rd_one = 1'b1; elem_after = S_M3; end
            S_M3: begin elem_up = 1'b0; wr_one = 1'b1; elem_after = S_M4; end
            S_M4: begin elem_up = 1'b0; rd_one = 1'b1; elem_after = S_M5; end
            S_M5: begin elem_wr = 1'b0; end
            default: begin in_elem = 1'b0; elem_rd = 1'b0; elem_wr = 1'b0; end
        endcase
    end

    assign elem_rw   = elem_rd & elem_wr;
    assign rd_issue  = elem_rd & (~elem_rw | ~phase_reg);
    assign wr_issue  = elem_wr & (~elem_rw | phase_reg);
    assign op_last   = ~elem_rw | phase_reg;
    assign elem_last = elem_up ? (&addr_reg) : (~|addr_reg);
    assign next_up   = !(elem_after inside {S_M3, S_M4});
    assign rd_val    = rd_one ? ~bg_reg : bg_reg;
    assign wr_val    = wr_one ? ~bg_reg : bg_reg;
    assign start_ok  = (state_reg == S_IDLE) && start_i;
    assign fin       = (state_reg == S_FIN);

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            phase_reg <= 1'b0;
            drain_reg <= '0;
            bg_reg    <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            phase_reg <= phase_next;
            drain_reg <= drain_next;
            if (start_ok)
                bg_reg <= bg_i;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        phase_next = phase_reg;
        drain_next = drain_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_M0;
                    addr_next  = '0;
                    phase_next = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LAST)
                    state_next = S_FIN;
                else
                    drain_next = drain_reg + 2'd1;
            end
            S_FIN: state_next = S_IDLE;
            default: begin
                if (stop_hit) begin
                    state_next = S_DRAIN;
                    drain_next = '0;
                    phase_next = 1'b0;
                end else if (!op_last) begin
                    phase_next = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    if (elem_last) begin
                        // Seamless hand-off: next element starts at its own first address.
                        state_next = elem_after;
                        addr_next  = next_up ? '0 : '1;
                        drain_next = '0;
                    end else begin
                        addr_next = elem_up ? addr_reg + ADDR_W'(1) : addr_reg - ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        mem_ena_o        = rd_issue | wr_issue;
        mem_wea_o        = wr_issue;
        mem_addr_o       = in_elem ? addr_reg : '0;
        mem_din_o        = wr_issue ? wr_val : '0;
        busy_o           = (state_reg != S_IDLE) && !fin;
        done_o           = fin;
        pass_o           = fin ? (err_cnt_reg == '0) : pass_reg;
        err_cnt_o        = err_cnt_reg;
        first_err_addr_o = first_addr_reg;
        first_err_data_o = first_data_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_vld_next[gi]  = rd_issue;
                assign pipe_addr_next[gi] = addr_reg;
                assign pipe_exp_next[gi]  = rd_val;
            end else begin : g_tail
                assign pipe_vld_next[gi]  = pipe_vld_reg[gi-1];
                assign pipe_addr_next[gi] = pipe_addr_reg[gi-1];
                assign pipe_exp_next[gi]  = pipe_exp_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_reg  <= '0;
            pipe_addr_reg <= '0;
            pipe_exp_reg  <= '0;
        end else if (start_ok) begin
            pipe_vld_reg  <= '0;
            pipe_addr_reg <= '0;
            pipe_exp_reg  <= '0;
        end else begin
            pipe_vld_reg  <= pipe_vld_next;
            pipe_addr_reg <= pipe_addr_next;
            pipe_exp_reg  <= pipe_exp_next;
        end
    end

    // The last pipeline stage lines up with douta of the read it tracks.
    assign mismatch = pipe_vld_reg[RD_LAT-1] && (mem_dout_i != pipe_exp_reg[RD_LAT-1]);

`ifdef MARCH_STOP_ON_FAIL_EN
    logic stop_reg;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n)
            stop_reg <= 1'b0;
        else if (start_ok)
            stop_reg <= 1'b0;
        else if (mismatch)
            stop_reg <= 1'b1;
    end

    assign count_en = mismatch & ~stop_reg;
    assign stop_hit = count_en & in_elem;
`else
    assign count_en = mismatch;
    assign stop_hit = 1'b0;
`endif

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg    <= '0;
            first_addr_reg <= '0;
            first_data_reg <= '0;
            pass_reg       <= 1'b0;
        end else begin
            if (start_ok) begin
                err_cnt_reg    <= '0;
                first_addr_reg <= '0;
                first_data_reg <= '0;
                pass_reg       <= 1'b0;
            end else if (count_en) begin
                if (err_cnt_reg != '1)
                    err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                // A saturating counter never returns to zero, so zero means "no earlier mismatch".
                if (err_cnt_reg == '0) begin
                    first_addr_reg <= pipe_addr_reg[RD_LAT-1];
                    first_data_reg <= mem_dout_i;
                end
            end
            if (fin)
                pass_reg <= (err_cnt_reg == '0);
        end
    end

endmodule

// File: tb/tb_mem_march_ctrl.sv
// Scoreboard bench for mem_march_ctrl: two instances (RD_LAT=1 and RD_LAT=2), ADDR_W=4,
// each with a behavioural RAM; the RD_LAT=1 RAM can plant a stuck-at-0 on bit0 of address 5.
`timescale 1ns/1ps
module tb_mem_march_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int EW = 16;
    localparam int N  = 16;
    localparam int TR = 170;
`ifdef MARCH_STOP_ON_FAIL_EN
    localparam int         FAULT_LAT = 62;
    localparam logic [15:0] FAULT_ERR = 16'd1;
`else
    localparam int         FAULT_LAT = 162;
    localparam logic [15:0] FAULT_ERR = 16'd2;
`endif

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        int          done_cyc;
        logic        pass;
        logic [15:0] err;
        logic [3:0]  faddr;
        logic [7:0]  fdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start1 = 1'b0, start2 = 1'b0;
    logic [DW-1:0] bg1 = '0, bg2 = '0;
    logic          ena1, wea1, ena2, wea2;
    logic [AW-1:0] addr1, addr2, faddr1, faddr2;
    logic [DW-1:0] din1, din2, dout1, dout2, fdata1, fdata2;
    logic          busy1, done1, pass1, busy2, done2, pass2;
    logic [EW-1:0] err1, err2;

    mem_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ERR_W(EW)) u_dut1 (
        .core_clk(clk), .rst_n(rst_n), .start_i(start1), .bg_i(bg1),
        .mem_ena_o(ena1), .mem_wea_o(wea1), .mem_addr_o(addr1), .mem_din_o(din1),
        .mem_dout_i(dout1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_cnt_o(err1), .first_err_addr_o(faddr1), .first_err_data_o(fdata1)
    );

    mem_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .ERR_W(EW)) u_dut2 (
        .core_clk(clk), .rst_n(rst_n), .start_i(start2), .bg_i(bg2),
        .mem_ena_o(ena2), .mem_wea_o(wea2), .mem_addr_o(addr2), .mem_din_o(din2),
        .mem_dout_i(dout2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .err_cnt_o(err2), .first_err_addr_o(faddr2), .first_err_data_o(fdata2)
    );

    // RAM models
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem2 [N];
    logic [DW-1:0] rd2_q;
    logic          fault1 = 1'b0;

    always @(posedge clk) begin
        if (ena1 && wea1)
            mem1[addr1] <= (fault1 && addr1 == 4'd5) ? (din1 & 8'hFE) : din1;
        if (ena1 && !wea1)
            dout1 <= (fault1 && addr1 == 4'd5) ? (mem1[addr1] & 8'hFE) : mem1[addr1];
    end

    always @(posedge clk) begin
        if (ena2 && wea2)
            mem2[addr2] <= din2;
        if (ena2 && !wea2)
            rd2_q <= mem2[addr2];
        dout2 <= rd2_q;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus trace per run, indexed by cycle offset from the first M0 cycle.
    int            base1 = -1000, base2 = -1000;
    int            tidx1, tidx2;
    logic [13:0]   tr1 [TR];
    logic [13:0]   tr2 [TR];

    initial forever begin
        @(negedge clk);
        tidx1 = cyc - base1;
        tidx2 = cyc - base2;
        if (tidx1 >= 0 && tidx1 < TR) tr1[tidx1] = {ena1, wea1, addr1, din1};
        if (tidx2 >= 0 && tidx2 < TR) tr2[tidx2] = {ena2, wea2, addr2, din2};
    end

    // Scoreboard
    chk_t chk_q[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail = 0;
    chk_t mon_c;
    exp_t mon_e;

    function automatic void post(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = nm;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, a, e);
        end
    endtask

    initial forever begin
        @(negedge clk);
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            check(mon_c.name, mon_c.act, mon_c.exp);
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                mon_e = q1.pop_front();
                $display("dut1 run done at cycle %0d: pass=%0b err=%0d first_addr=%0d first_data=%02h",
                         cyc, pass1, err1, faddr1, fdata1);
                check("dut1 done cycle", cyc, mon_e.done_cyc);
                check("dut1 pass", {31'd0, pass1}, {31'd0, mon_e.pass});
                check("dut1 err_cnt", {16'd0, err1}, {16'd0, mon_e.err});
                check("dut1 first_err_addr", {28'd0, faddr1}, {28'd0, mon_e.faddr});
                check("dut1 first_err_data", {24'd0, fdata1}, {24'd0, mon_e.fdata});
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected done", 32'd1, 32'd0);
            end else begin
                mon_e = q2.pop_front();
                $display("dut2 run done at cycle %0d: pass=%0b err=%0d first_addr=%0d first_data=%02h",
                         cyc, pass2, err2, faddr2, fdata2);
                check("dut2 done cycle", cyc, mon_e.done_cyc);
                check("dut2 pass", {31'd0, pass2}, {31'd0, mon_e.pass});
                check("dut2 err_cnt", {16'd0, err2}, {16'd0, mon_e.err});
            end
        end
    end

    task automatic start_run1(input logic [7:0] bg, output int st);
        @(negedge clk);
        bg1    = bg;
        start1 = 1'b1;
        st     = cyc;
        base1  = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic start_run2(input logic [7:0] bg, output int st);
        @(negedge clk);
        bg2    = bg;
        start2 = 1'b1;
        st     = cyc;
        base2  = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done1(input string nm);
        int k = 0;
        while (done1 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done1 !== 1'b1) post({nm, " done timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done2(input string nm);
        int k = 0;
        while (done2 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done2 !== 1'b1) post({nm, " done timeout"}, 32'd0, 32'd1);
    endtask

    function automatic exp_t mk(input int dc, input logic p, input logic [15:0] e,
                                input logic [3:0] a, input logic [7:0] d);
        exp_t x;
        x.done_cyc = dc;
        x.pass     = p;
        x.err      = e;
        x.faddr    = a;
        x.fdata    = d;
        return x;
    endfunction

    initial begin : main
        int st;
        repeat (3) @(negedge clk);
        post("reset busy", {31'd0, busy1}, 32'd0);
        post("reset done", {31'd0, done1}, 32'd0);
        post("reset pass", {31'd0, pass1}, 32'd0);
        post("reset err_cnt", {16'd0, err1}, 32'd0);
        post("reset first_err", {20'd0, faddr1, fdata1}, 32'd0);
        post("reset mem bus", {18'd0, ena1, wea1, addr1, din1}, 32'd0);
        rst_n = 1'b1;

        // Fault-free, background 0x00
        fault1 = 1'b0;
        start_run1(8'h00, st);
        q1.push_back(mk(st + 162, 1'b1, 16'd0, 4'd0, 8'h00));
        wait_done1("t1");
        for (int i = 0; i < 16; i++)
            post($sformatf("t1 M0 write %0d", i), {18'd0, tr1[i]}, {18'd0, 1'b1, 1'b1, 4'(i), 8'h00});
        for (int k = 0; k < 16; k++) begin
            post($sformatf("t1 M3 read %0d", k), {18'd0, tr1[80 + 2*k]},
                 {18'd0, 1'b1, 1'b0, 4'(15 - k), 8'h00});
            post($sformatf("t1 M3 write %0d", k), {18'd0, tr1[81 + 2*k]},
                 {18'd0, 1'b1, 1'b1, 4'(15 - k), 8'hFF});
        end

        // Stuck-at-0 on bit0 of address 5
        fault1 = 1'b1;
        start_run1(8'h00, st);
        q1.push_back(mk(st + FAULT_LAT, 1'b0, FAULT_ERR, 4'd5, 8'hFE));
        wait_done1("t2");

        // RD_LAT=2 instance, background 0xA5
        start_run2(8'hA5, st);
        q2.push_back(mk(st + 163, 1'b1, 16'd0, 4'd0, 8'h00));
        wait_done2("t3");
        for (int k = 0; k < 16; k++) begin
            post($sformatf("t3 M1 write %0d", k), {18'd0, tr2[17 + 2*k]},
                 {18'd0, 1'b1, 1'b1, 4'(k), 8'h5A});
            post($sformatf("t3 M2 write %0d", k), {18'd0, tr2[49 + 2*k]},
                 {18'd0, 1'b1, 1'b1, 4'(k), 8'hA5});
        end

        // Reset abort at cycle 40 of a run
        fault1 = 1'b0;
        start_run1(8'h00, st);
        repeat (39) @(negedge clk);
        post("t4 busy before reset", {31'd0, busy1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        post("t4 ena during reset", {31'd0, ena1}, 32'd0);
        post("t4 busy during reset", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        post("t4 idle after reset", {30'd0, busy1, ena1}, 32'd0);
        start_run1(8'h00, st);
        q1.push_back(mk(st + 162, 1'b1, 16'd0, 4'd0, 8'h00));
        wait_done1("t4");

        // Start pulses mid-run, during FIN, then in IDLE
        fault1 = 1'b1;
        start_run1(8'h00, st);
        q1.push_back(mk(st + FAULT_LAT, 1'b0, FAULT_ERR, 4'd5, 8'hFE));
        repeat (20) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1("t5a");
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        post("t5 busy after FIN pulse", {31'd0, busy1}, 32'd0);
        post("t5 err kept after FIN pulse", {16'd0, err1}, {16'd0, FAULT_ERR});
        fault1 = 1'b0;
        start_run1(8'h00, st);
        post("t5 err cleared by start", {16'd0, err1}, 32'd0);
        post("t5 busy after start", {31'd0, busy1}, 32'd1);
        q1.push_back(mk(st + 162, 1'b1, 16'd0, 4'd0, 8'h00));
        wait_done1("t5b");

        repeat (2) @(negedge clk);
        post("dut1 pending results", q1.size(), 32'd0);
        post("dut2 pending results", q2.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
